axi4lite_initiator: RTL and testbench
=====================================

# axi4lite_initiator

Single-outstanding AXI4-lite initiator that turns a simple valid/ready word request port into AXI4-lite read or write transactions and returns one response per request. It sits between a hart's load/store or fetch path and the AXI4-lite interconnect, and drives targets such as the timer/IPI block, UART and RAM bridges. It is the initiator-side counterpart of the AXI4-lite target blocks in this design.

## Interface
- AWIDTH, 32, address width of `req_addr` and the AXI `araddr`/`awaddr`
- DWIDTH, 32, data width; the only supported value is 32
- clk  in  1  sole clock; all logic is `posedge clk`
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when `req_valid && req_ready`
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AWIDTH  byte address, passed through to AXI unmodified
- req_wdata  in  DWIDTH  write data; full-word writes only
- rsp_valid  out  1  one-cycle pulse, response ready
- rsp_rdata  out  DWIDTH  read data; 0 for writes
- rsp_err  out  1  1 when `rresp`/`bresp` is not OKAY
- axi_if  `axi4lite_if.initiator_port`  drives `arvalid`, `araddr`, `rready`, `awvalid`, `awaddr`, `wvalid`, `wdata`, `bready`; uses `ardone`, `rdone`, `awdone`, `wdone`, `bdone`

## Operation
- FSM states: IDLE, RD_A, RD_D, WR, WR_B, RSP.
- IDLE
  - `req_ready`=1.
  - On accept, latch addr/wdata.
  - Read → RD_A, write → WR.
- RD_A
  - `arvalid`=1 with the latched address.
  - On `ardone` → RD_D.
- RD_D
  - `rready`=1.
  - On `rdone`: latch `rdata`; set err = `rresp[1]`; → RSP.
- WR
  - `awvalid` and `wvalid` both start at 1.
  - Each drops independently after its own done (`aw_pend`/`w_pend` flags).
  - When both are done (same cycle allowed) → WR_B.
- WR_B
  - `bready`=1.
  - On `bdone`: set err = `bresp[1]`; → RSP.
- RSP
  - `rsp_valid`=1 for exactly one cycle; `rsp_rdata` and `rsp_err` are valid in that cycle.
  - → IDLE.
- At most one transaction outstanding; no pipelining; reads and writes never overlap.
- Address and data stay stable while the corresponding valid is high (AXI rule). A valid is never withdrawn before its handshake.
- `rsp_rdata` is held between responses; it is cleared to 0 on a write response.
- Reset mid-operation:
  - All outputs take their reset values on the next edge; state → IDLE.
  - The in-flight transaction is abandoned with no `rsp_valid`.
  - The bench/interconnect is reset together with this block.

## Timing
- All outputs are registered.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `arvalid`=`awvalid`=`wvalid`=`rready`=`bready`=0.
  - `req_ready` rises on the first edge after `rst` deasserts.
- Request accepted at edge N → `req_ready`=0 and `arvalid` (or `awvalid`+`wvalid`)=1 from cycle N+1.
- Read with zero-wait target:
  - `ardone` at N+1.
  - `rready` from N+2; `rdone` at N+2.
  - `rsp_valid` at N+3.
  - `req_ready` at N+4.
- Write with zero-wait target:
  - `awdone`/`wdone` at N+1.
  - `bready` N+2; `bdone` N+2.
  - `rsp_valid` N+3.
- Minimum request spacing is 4 cycles. Each AXI wait state adds exactly one cycle.
- `rready`/`bready` are low outside RD_D/WR_B.
- `ready` is never asserted before the state it belongs to.

## Test plan
- Read 0x0200_BFF8; target returns `rdata`=0x1234_5678, `rresp`=OKAY, zero wait → `araddr`=0x0200_BFF8 at N+1, `rsp_valid` at N+3 with `rsp_rdata`=0x1234_5678, `rsp_err`=0.
- Write 0x0200_4000 data 0xDEAD_BEEF with `awready` delayed 3 cycles and `wready` immediate → `wvalid` high for 1 cycle, `awvalid` for 4 cycles, `bready` only after both dones, `rsp_valid` 1 cycle after `bdone`, `rsp_rdata`=0.
- Write with `wready` before `awready`, then same-cycle AW/W completion → both orders reach WR_B; exactly one `rsp_valid` each.
- Read with `rresp`=2'b10 (SLVERR), then write with `bresp`=2'b11 (DECERR) → `rsp_err`=1 both times; the following OKAY read gives `rsp_err`=0.
- `req_valid` held high with two queued reads → second accepted at the edge after the first `rsp_valid` cycle; never two `arvalid` bursts overlapping; `araddr` stable while `arvalid`.
- Assert `rst` while in RD_D with `rvalid` low → next cycle all valids/readies 0 and `rsp_valid` 0. After release, `req_ready`=1 one cycle later and a fresh read completes normally.

Source files
------------

// File: rtl/axi4lite_initiator_if.sv
// AXI4-lite channel bundle between an initiator and a target.
// The *done strobes flag the cycle in which each channel handshake completes.
interface axi4lite_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              arvalid;
    logic              arready;
    logic [AWIDTH-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        rresp;
    logic              awvalid;
    logic              awready;
    logic [AWIDTH-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DWIDTH-1:0] wdata;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              ardone;
    logic              rdone;
    logic              awdone;
    logic              wdone;
    logic              bdone;

    assign ardone = arvalid && arready;
    assign rdone  = rvalid  && rready;
    assign awdone = awvalid && awready;
    assign wdone  = wvalid  && wready;
    assign bdone  = bvalid  && bready;

    modport initiator_port (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
        input  ardone, rdone, awdone, wdone, bdone, rdata, rresp, bresp
    );

    modport target_port (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
        input  ardone, rdone, awdone, wdone, bdone
    );
endinterface

// File: rtl/axi4lite_initiator.sv
// Single-outstanding AXI4-lite initiator: one word request in, one AXI read or
// write transaction out, one registered response pulse back.
module axi4lite_initiator #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AWIDTH-1:0]  req_addr,
    input  logic [DWIDTH-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DWIDTH-1:0]  rsp_rdata,
    output logic               rsp_err,
    axi4lite_if.initiator_port axi_if
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RSP} state_t;

    state_t            state;
    state_t            state_n;
    logic              ar_valid;
    logic              r_ready;
    logic              b_ready;
    logic              aw_pend;
    logic              w_pend;
    logic              aw_pend_n;
    logic              w_pend_n;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_n;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] wdata_n;
    logic [DWIDTH-1:0] rdata_n;
    logic              err_n;
    logic              resp_unused;

    assign axi_if.arvalid = ar_valid;
    assign axi_if.araddr  = addr_q;
    assign axi_if.rready  = r_ready;
    assign axi_if.awvalid = aw_pend;
    assign axi_if.awaddr  = addr_q;
    assign axi_if.wvalid  = w_pend;
    assign axi_if.wdata   = wdata_q;
    assign axi_if.bready  = b_ready;

    // Only bit 1 of a response separates OKAY/EXOKAY from SLVERR/DECERR.
    assign resp_unused = axi_if.rresp[0] ^ axi_if.bresp[0];

    always_comb begin
        state_n   = state;
        aw_pend_n = aw_pend;
        w_pend_n  = w_pend;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rdata_n   = rsp_rdata;
        err_n     = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    if (req_we) begin
                        state_n   = WR;
                        aw_pend_n = 1'b1;
                        w_pend_n  = 1'b1;
                    end else begin
                        state_n = RD_A;
                    end
                end
            end
            RD_A: begin
                if (axi_if.ardone) state_n = RD_D;
            end
            RD_D: begin
                if (axi_if.rdone) begin
                    rdata_n = axi_if.rdata;
                    err_n   = axi_if.rresp[1];
                    state_n = RSP;
                end
            end
            // AW and W complete independently, in either order or together.
            WR: begin
                if (axi_if.awdone) aw_pend_n = 1'b0;
                if (axi_if.wdone)  w_pend_n  = 1'b0;
                if (!aw_pend_n && !w_pend_n) state_n = WR_B;
            end
            WR_B: begin
                if (axi_if.bdone) begin
                    rdata_n = '0;
                    err_n   = axi_if.bresp[1];
                    state_n = RSP;
                end
            end
            RSP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Every handshake output is decoded from the next state so it is registered
    // and appears in the first cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            b_ready   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == RSP);
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            ar_valid  <= (state_n == RD_A);
            r_ready   <= (state_n == RD_D);
            aw_pend   <= (state_n == WR) && aw_pend_n;
            w_pend    <= (state_n == WR) && w_pend_n;
            b_ready   <= (state_n == WR_B);
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
        end
    end
endmodule

// File: tb/tb_axi4lite_initiator.sv
// Bench for axi4lite_initiator: a configurable-latency AXI4-lite target plus a
// scoreboard of expected responses popped as rsp_valid pulses arrive.
module tb_axi4lite_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    axi4lite_if #(.AWIDTH(32), .DWIDTH(32)) axi ();

    axi4lite_initiator #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .axi_if    (axi)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Target behaviour knobs
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rd_val = '0;
    bit          rd_xor = 1'b0;
    logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;
    logic [31:0] seen_araddr = '0, seen_awaddr = '0, seen_wdata = '0;

    // Scoreboard and monitor queues
    logic [31:0] exp_data_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    logic [31:0] rsp_data_q[$];
    logic        rsp_err_q[$];
    int          rsp_cyc_q[$];
    int          acc_q[$];
    int          cyc = 0;

    int aw_hi = 0, w_hi = 0, ar_bursts = 0, rsp_count = 0;
    int viol_addr = 0, viol_overlap = 0, viol_ready = 0, viol_pulse = 0;

    // AXI4-lite target: samples handshakes at the edge, drives just after it.
    initial begin : target
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        bit r_pend, b_pend, aw_got, w_got;
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.rdata = '0; axi.rresp = 2'b00; axi.bresp = 2'b00;
        forever begin
            @(posedge clk);
            ar_hs = (axi.arvalid === 1'b1) && (axi.arready === 1'b1);
            r_hs  = (axi.rvalid  === 1'b1) && (axi.rready  === 1'b1);
            aw_hs = (axi.awvalid === 1'b1) && (axi.awready === 1'b1);
            w_hs  = (axi.wvalid  === 1'b1) && (axi.wready  === 1'b1);
            b_hs  = (axi.bvalid  === 1'b1) && (axi.bready  === 1'b1);
            if (ar_hs) seen_araddr = axi.araddr;
            if (aw_hs) seen_awaddr = axi.awaddr;
            if (w_hs)  seen_wdata  = axi.wdata;
            #1;
            if (rst) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            end else begin
                if (r_hs) r_pend = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; end
                if (b_hs) b_pend = 0;
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
                if (axi.arvalid === 1'b1) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin axi.arready = 0; ar_cnt = 0; end
                if (axi.awvalid === 1'b1) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin axi.awready = 0; aw_cnt = 0; end
                if (axi.wvalid === 1'b1) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
                else begin axi.wready = 0; w_cnt = 0; end
                if (r_pend) begin axi.rvalid = (r_cnt >= r_dly); r_cnt++; end
                else axi.rvalid = 0;
                if (b_pend) begin axi.bvalid = (b_cnt >= b_dly); b_cnt++; end
                else axi.bvalid = 0;
                axi.rdata = rd_xor ? (rd_val ^ seen_araddr) : rd_val;
                axi.rresp = rresp_val;
                axi.bresp = bresp_val;
            end
        end
    end

    // Request acceptance is recorded with the number of the cycle it happened in.
    initial forever begin
        @(posedge clk);
        if (req_valid === 1'b1 && req_ready === 1'b1) acc_q.push_back(cyc);
        cyc++;
    end

    // Response capture and protocol observation, mid-cycle.
    initial begin : monitor
        logic        prev_ar, prev_rsp;
        logic [31:0] prev_araddr;
        prev_ar = 0; prev_rsp = 0; prev_araddr = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rsp_data_q.push_back(rsp_rdata);
                rsp_err_q.push_back(rsp_err);
                rsp_cyc_q.push_back(cyc);
                rsp_count++;
                if (prev_rsp) viol_pulse++;
            end
            if (axi.awvalid === 1'b1) aw_hi++;
            if (axi.wvalid === 1'b1) w_hi++;
            if (axi.arvalid === 1'b1 && !prev_ar) ar_bursts++;
            if (axi.arvalid === 1'b1 && prev_ar && axi.araddr !== prev_araddr) viol_addr++;
            if (axi.arvalid === 1'b1 && (axi.awvalid === 1'b1 || axi.wvalid === 1'b1)) viol_overlap++;
            if (axi.bready === 1'b1 && (axi.awvalid === 1'b1 || axi.wvalid === 1'b1)) viol_ready++;
            if (axi.rready === 1'b1 && axi.arvalid === 1'b1) viol_ready++;
            prev_ar     = (axi.arvalid === 1'b1);
            prev_rsp    = (rsp_valid === 1'b1);
            prev_araddr = axi.araddr;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            output bit ok);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (req_ready === 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n_exp, output bit ok);
        int n = 0;
        while (rsp_data_q.size() < n_exp && n < 100) begin @(negedge clk); #1; n++; end
        ok = (rsp_data_q.size() >= n_exp);
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] xd, input logic xe, input int xl, output bit ok);
        bit ok_req, ok_rsp;
        exp_data_q.push_back(xd); exp_err_q.push_back(xe); exp_lat_q.push_back(xl);
        send_req(we, addr, data, ok_req);
        wait_rsp(1, ok_rsp);
        ok = ok_req && ok_rsp;
    endtask

    task automatic pop_rsp(output logic [31:0] d, output logic e, output int acc, output int rc,
                           output logic [31:0] xd, output logic xe, output int xl);
        d   = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'hxxxx_xxxx;
        e   = (rsp_err_q.size()  > 0) ? rsp_err_q.pop_front()  : 1'bx;
        rc  = (rsp_cyc_q.size()  > 0) ? rsp_cyc_q.pop_front()  : -1000;
        acc = (acc_q.size()      > 0) ? acc_q.pop_front()      : -2000;
        xd  = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'h0;
        xe  = (exp_err_q.size()  > 0) ? exp_err_q.pop_front()  : 1'b0;
        xl  = (exp_lat_q.size()  > 0) ? exp_lat_q.pop_front()  : 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin n_fail++;
            $display("[TB] FAIL reset_axi: got %b expected 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_read_basic();
        bit ok; logic [31:0] d, xd; logic e, xe; int acc, rc, xl;
        rd_val = 32'h1234_5678;
        run_txn(1'b0, 32'h0200_BFF8, 32'h0, 32'h1234_5678, 1'b0, 3, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rd_done: got timeout expected response"); end
        n_cmp++; if (seen_araddr !== 32'h0200_BFF8) begin n_fail++; $display("[TB] FAIL rd_araddr: got %h expected 0200bff8", seen_araddr); end
        n_cmp++; if (d !== xd) begin n_fail++; $display("[TB] FAIL rd_data: got %h expected %h", d, xd); end
        n_cmp++; if (e !== xe) begin n_fail++; $display("[TB] FAIL rd_err: got %b expected %b", e, xe); end
        n_cmp++; if (rc - acc !== xl) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d expected %0d", rc - acc, xl); end
    endtask

    task automatic test_write_aw_delay();
        bit ok; logic [31:0] d, xd; logic e, xe; int acc, rc, xl;
        aw_dly = 3; w_dly = 0;
        aw_hi = 0; w_hi = 0; viol_ready = 0;
        run_txn(1'b1, 32'h0200_4000, 32'hDEAD_BEEF, 32'h0, 1'b0, 6, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL wr_done: got timeout expected response"); end
        n_cmp++; if (seen_awaddr !== 32'h0200_4000) begin n_fail++; $display("[TB] FAIL wr_awaddr: got %h expected 02004000", seen_awaddr); end
        n_cmp++; if (seen_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL wr_wdata: got %h expected deadbeef", seen_wdata); end
        n_cmp++; if (aw_hi !== 4) begin n_fail++; $display("[TB] FAIL wr_awvalid_cycles: got %0d expected 4", aw_hi); end
        n_cmp++; if (w_hi !== 1) begin n_fail++; $display("[TB] FAIL wr_wvalid_cycles: got %0d expected 1", w_hi); end
        n_cmp++; if (viol_ready !== 0) begin n_fail++; $display("[TB] FAIL wr_bready_early: got %0d expected 0", viol_ready); end
        n_cmp++; if (d !== xd) begin n_fail++; $display("[TB] FAIL wr_rdata_clear: got %h expected %h", d, xd); end
        n_cmp++; if (e !== xe) begin n_fail++; $display("[TB] FAIL wr_err: got %b expected %b", e, xe); end
        n_cmp++; if (rc - acc !== xl) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected %0d", rc - acc, xl); end
        aw_dly = 0;
    endtask

    task automatic test_write_orders();
        bit ok; logic [31:0] d, xd; logic e, xe; int acc, rc, xl, base;
        int aw_tab[3] = '{2, 0, 2};
        int w_tab[3]  = '{0, 2, 2};
        base = rsp_count;
        viol_ready = 0;
        for (int i = 0; i < 3; i++) begin
            aw_dly = aw_tab[i]; w_dly = w_tab[i];
            run_txn(1'b1, 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0, 1'b0, 5, ok);
            pop_rsp(d, e, acc, rc, xd, xe, xl);
            n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL order%0d_done: got timeout expected response", i); end
            n_cmp++; if (seen_wdata !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("[TB] FAIL order%0d_wdata: got %h expected %h", i, seen_wdata, 32'hA000_0000 + 32'(i)); end
            n_cmp++; if (rc - acc !== xl) begin n_fail++; $display("[TB] FAIL order%0d_latency: got %0d expected %0d", i, rc - acc, xl); end
        end
        repeat (4) @(negedge clk); #1;
        n_cmp++; if (rsp_count - base !== 3) begin n_fail++; $display("[TB] FAIL order_rsp_count: got %0d expected 3", rsp_count - base); end
        n_cmp++; if (viol_ready !== 0) begin n_fail++; $display("[TB] FAIL order_bready_early: got %0d expected 0", viol_ready); end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_errors();
        bit ok; logic [31:0] d, xd; logic e, xe; int acc, rc, xl;
        rresp_val = 2'b10; rd_val = 32'hCAFE_0001;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_0001, 1'b1, 3, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (e !== xe || !ok) begin n_fail++; $display("[TB] FAIL slverr_err: got %b expected %b", e, xe); end
        n_cmp++; if (d !== xd) begin n_fail++; $display("[TB] FAIL slverr_data: got %h expected %h", d, xd); end
        rresp_val = 2'b00; bresp_val = 2'b11;
        run_txn(1'b1, 32'h0000_0044, 32'h1111_2222, 32'h0, 1'b1, 3, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (e !== xe || !ok) begin n_fail++; $display("[TB] FAIL decerr_err: got %b expected %b", e, xe); end
        n_cmp++; if (d !== xd) begin n_fail++; $display("[TB] FAIL decerr_data: got %h expected %h", d, xd); end
        bresp_val = 2'b00; rd_val = 32'h0BAD_F00D;
        run_txn(1'b0, 32'h0000_0048, 32'h0, 32'h0BAD_F00D, 1'b0, 3, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (e !== xe || !ok) begin n_fail++; $display("[TB] FAIL okay_after_err: got %b expected %b", e, xe); end
        n_cmp++; if (d !== xd) begin n_fail++; $display("[TB] FAIL okay_after_err_data: got %h expected %h", d, xd); end
    endtask

    task automatic test_back_to_back();
        bit ok; int n; logic [31:0] d1, d2, xd1, xd2; logic e1, e2, xe1, xe2;
        int acc1, acc2, rc1, rc2, xl1, xl2;
        logic [31:0] a1 = 32'h0000_0100, a2 = 32'h0000_0204;
        ar_dly = 2; rd_xor = 1'b1; rd_val = 32'h5A5A_0000;
        ar_bursts = 0; viol_addr = 0; viol_overlap = 0;
        exp_data_q.push_back(rd_val ^ a1); exp_err_q.push_back(1'b0); exp_lat_q.push_back(5);
        exp_data_q.push_back(rd_val ^ a2); exp_err_q.push_back(1'b0); exp_lat_q.push_back(5);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a1;
        n = 0; while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_addr = a2;
        @(negedge clk);
        n = 0; while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(2, ok);
        pop_rsp(d1, e1, acc1, rc1, xd1, xe1, xl1);
        pop_rsp(d2, e2, acc2, rc2, xd2, xe2, xl2);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL b2b_done: got timeout expected two responses"); end
        n_cmp++; if (d1 !== xd1) begin n_fail++; $display("[TB] FAIL b2b_data1: got %h expected %h", d1, xd1); end
        n_cmp++; if (d2 !== xd2) begin n_fail++; $display("[TB] FAIL b2b_data2: got %h expected %h", d2, xd2); end
        n_cmp++; if (rc1 - acc1 !== xl1) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", rc1 - acc1, xl1); end
        n_cmp++; if (acc2 !== rc1 + 1) begin n_fail++; $display("[TB] FAIL b2b_second_accept: got cycle %0d expected %0d", acc2, rc1 + 1); end
        n_cmp++; if (acc2 - acc1 !== 6) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d expected 6", acc2 - acc1); end
        n_cmp++; if (ar_bursts !== 2) begin n_fail++; $display("[TB] FAIL b2b_ar_bursts: got %0d expected 2", ar_bursts); end
        n_cmp++; if (viol_addr !== 0) begin n_fail++; $display("[TB] FAIL b2b_araddr_stable: got %0d changes expected 0", viol_addr); end
        n_cmp++; if (viol_overlap !== 0) begin n_fail++; $display("[TB] FAIL b2b_overlap: got %0d expected 0", viol_overlap); end
        n_cmp++; if (viol_pulse !== 0) begin n_fail++; $display("[TB] FAIL rsp_pulse_width: got %0d long pulses expected 0", viol_pulse); end
        ar_dly = 0; rd_xor = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok; int n; logic [31:0] d, xd; logic e, xe; int acc, rc, xl;
        r_dly = 20; rd_val = 32'h7777_0001;
        send_req(1'b0, 32'h0000_0300, 32'h0, ok);
        n = 0; while (axi.rready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        n_cmp++; if (axi.rready !== 1'b1 || axi.rvalid !== 1'b0) begin n_fail++;
            $display("[TB] FAIL mid_reach_rd_d: got rready=%b rvalid=%b expected 1 0", axi.rready, axi.rvalid); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin n_fail++;
            $display("[TB] FAIL mid_reset_axi: got %b expected 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
        n_cmp++; if ({req_ready, rsp_valid, rsp_err} !== 3'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ctl: got %b expected 000", {req_ready, rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_reset_rdata: got %h expected 0", rsp_rdata); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_release_ready: got %b expected 1", req_ready); end
        repeat (6) @(negedge clk); #1;
        n_cmp++; if (rsp_data_q.size() !== 0) begin n_fail++; $display("[TB] FAIL mid_abandoned_rsp: got %0d responses expected 0", rsp_data_q.size()); end
        rsp_data_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete(); acc_q.delete();
        r_dly = 0;
        run_txn(1'b0, 32'h0000_0310, 32'h0, 32'h7777_0001, 1'b0, 3, ok);
        pop_rsp(d, e, acc, rc, xd, xe, xl);
        n_cmp++; if (!ok || d !== xd) begin n_fail++; $display("[TB] FAIL mid_fresh_read: got %h expected %h", d, xd); end
        n_cmp++; if (rc - acc !== xl) begin n_fail++; $display("[TB] FAIL mid_fresh_latency: got %0d expected %0d", rc - acc, xl); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_aw_delay();
        test_write_orders();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
